multdiv_sequencer: RTL and testbench
====================================

# multdiv_sequencer

Controls the shared multi-cycle multiplier/divider for the 5-stage pipeline. It accepts one mult/div operation at a time from the execute stage and drives the multdiv start pulses and operands. It tracks the busy destination register, stalls decode on a read-after-write hazard, and arbitrates the result into the regfile write port against the normal MW writeback. On a multdiv exception it redirects the write to rstatus.

## Interface
Parameters:
- TIMEOUT, 40: max cycles spent in WAIT before the operation is abandoned.
- RSTATUS_REG, 30: register written on a multdiv exception.
- MULT_EXC_CODE, 4: value written to rstatus on a mult exception.
- DIV_EXC_CODE, 5: value written to rstatus on a div exception.

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- issue_valid  in  1  execute stage holds a mult/div instruction.
- issue_op  in  1  0 = mult, 1 = div.
- issue_rd  in  5  destination register.
- issue_a, issue_b  in  32  bypassed operands.
- dec_rs1, dec_rs2  in  5  source registers of the instruction in decode.
- issue_stall  out  1  execute must hold; the unit cannot accept.
- hazard_stall  out  1  decode reads a register the unit will write.
- md_a, md_b  out  32  latched operands to multdiv.
- md_mult, md_div  out  1  one-cycle start pulses.
- md_result  in  32  multdiv result.
- md_exception  in  1  multdiv overflow / divide-by-zero.
- md_ready  in  1  result valid, one-cycle pulse.
- wb_req  out  1  request for the regfile write port.
- wb_reg  out  5  register to write.
- wb_data  out  32  data to write.
- wb_grant  in  1  pipeline grants the port this cycle; MW writeback has priority.
- busy  out  1  state is not IDLE.
- timeout_err  out  1  sticky; set by a timeout.

## Operation
- States: IDLE, START, WAIT, COMMIT. The state is 2-bit registered.
- Registers: op, rd, a, b, res, exc, and a 6-bit counter cnt.
- IDLE:
  - issue_stall is 0.
  - On issue_valid, latch op, rd, a and b, then go to START.
- START:
  - Assert md_mult if op = 0, otherwise md_div, for exactly one cycle.
  - Clear cnt, then go to WAIT.
- WAIT:
  - cnt increments each cycle.
  - On md_ready, latch md_result into res and md_exception into exc, then go to COMMIT.
  - If cnt = TIMEOUT-1 without md_ready, set timeout_err and go to IDLE with no writeback.
- md_ready is ignored in IDLE, START and COMMIT.
- COMMIT:
  - If exc = 1: wb_req = 1, wb_reg = RSTATUS_REG, wb_data = MULT_EXC_CODE or DIV_EXC_CODE according to op.
  - If exc = 0 and rd ≠ 0: wb_req = 1, wb_reg = rd, wb_data = res.
  - If exc = 0 and rd = 0: wb_req = 0 and the state goes to IDLE in one cycle.
  - wb_req, wb_reg and wb_data hold until wb_grant, then go to IDLE.
- issue_stall = issue_valid AND state ≠ IDLE.
- hazard_stall = busy AND (dec_rs1 or dec_rs2 equals rd with rd ≠ 0, OR either equals RSTATUS_REG).
- md_a and md_b hold their latched values from START until the next accept.
- Widths: operands and result pass through unmodified. cnt saturates and never wraps within TIMEOUT ≤ 63.

## Timing
- Reset (reset = 0), asynchronous:
  - State is IDLE; cnt and all latched registers are 0.
  - All outputs are 0, including timeout_err.
  - An operation in flight is dropped and any later md_ready is ignored.
- Accept at edge E:
  - START, with the md_mult/md_div pulse, is the cycle E..E+1.
  - WAIT begins at E+1.
- A multdiv latency of L cycles after the pulse gives md_ready in WAIT. wb_req asserts the cycle after md_ready is sampled.
- Minimum accept-to-wb_req is 3 cycles (md_ready in the first WAIT cycle).
- Back-to-back issue: a second issue_valid is stalled until the first commit is granted. It is accepted in the cycle the state returns to IDLE.
- wb_grant low during COMMIT causes no loss; the request holds for any number of cycles.
- wb_grant while wb_req = 0 is ignored.
- busy rises the cycle after accept and falls the cycle after grant or timeout.

## Test plan
- Mult with a = 6, b = 7, rd = 5, md_ready 17 cycles after the pulse, wb_grant held at 1:
  - md_mult pulses one cycle; md_div stays 0.
  - wb_req rises one cycle after md_ready with wb_reg = 5, wb_data = 42.
  - The state is back in IDLE after the grant.
- Div with md_exception = 1 and rd = 9:
  - The commit writes wb_reg = 30, wb_data = 5.
  - A mult exception gives wb_data = 4.
- Decode reads rs1 = 5 while a mult to r5 is in flight:
  - hazard_stall = 1 until the cycle after the grant.
  - rd = 0 never raises hazard_stall from rd.
- Hold wb_grant = 0 for 4 cycles in COMMIT: wb_req, wb_reg and wb_data are stable, and the commit completes on the first grant.
- Second issue_valid during WAIT:
  - issue_stall = 1 and no second start pulse occurs.
  - The second operation is accepted after the first commit; both results are correct.
- Robustness cases:
  - With no md_ready for 40 cycles: timeout_err = 1, no wb_req, state returns to IDLE.
  - Drive reset = 0 mid-WAIT, then md_ready: all outputs stay 0 and nothing commits.

Source files
------------

// File: rtl/multdiv_seq_if.sv
// Bundle of every handshake between the multdiv sequencer, the pipeline and the multdiv unit.
// The sequencer connects through the master modport; the surrounding pipeline uses the slave modport.
interface multdiv_seq_if;
  logic        issue_valid;
  logic        issue_op;
  logic [4:0]  issue_rd;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        issue_stall;
  logic        hazard_stall;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_mult;
  logic        md_div;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic        wb_req;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_grant;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  issue_valid, issue_op, issue_rd, issue_a, issue_b, dec_rs1, dec_rs2,
    input  md_result, md_exception, md_ready, wb_grant,
    output issue_stall, hazard_stall, md_a, md_b, md_mult, md_div,
    output wb_req, wb_reg, wb_data, busy, timeout_err
  );

  modport slave (
    output issue_valid, issue_op, issue_rd, issue_a, issue_b, dec_rs1, dec_rs2,
    output md_result, md_exception, md_ready, wb_grant,
    input  issue_stall, hazard_stall, md_a, md_b, md_mult, md_div,
    input  wb_req, wb_reg, wb_data, busy, timeout_err
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Sequences one mult/div at a time through the shared multdiv unit, guards the busy
// destination against RAW hazards and arbitrates the result onto the regfile write port.
module multdiv_sequencer #(
  parameter int TIMEOUT       = 40,
  parameter int RSTATUS_REG   = 30,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5
) (
  input logic          clock,
  input logic          reset,
  multdiv_seq_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_COMMIT} state_t;

  localparam logic [5:0]  CNT_LAST  = 6'(TIMEOUT - 1);
  localparam logic [5:0]  CNT_MAX   = 6'h3f;
  localparam logic [4:0]  RSTATUS   = 5'(RSTATUS_REG);
  localparam logic [31:0] MULT_CODE = 32'(MULT_EXC_CODE);
  localparam logic [31:0] DIV_CODE  = 32'(DIV_EXC_CODE);

  state_t      r_state;
  state_t      w_next;
  logic        r_op;
  logic [4:0]  r_rd;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_res;
  logic        r_exc;
  logic [5:0]  r_cnt;
  logic        r_timeout_err;

  logic        w_accept;
  logic        w_ready;
  logic        w_timeout;
  logic        w_wb_req;
  logic [4:0]  w_wb_reg;
  logic [31:0] w_wb_data;
  logic        w_rd_hit;
  logic        w_rstatus_hit;

  assign w_accept  = (r_state == S_IDLE) && bus.issue_valid;
  assign w_ready   = (r_state == S_WAIT) && bus.md_ready;
  assign w_timeout = (r_state == S_WAIT) && !bus.md_ready && (r_cnt == CNT_LAST);

  always_comb begin
    w_next    = r_state;
    w_wb_req  = 1'b0;
    w_wb_reg  = 5'd0;
    w_wb_data = 32'd0;
    case (r_state)
      S_IDLE:  if (bus.issue_valid) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.md_ready)           w_next = S_COMMIT;
        else if (r_cnt == CNT_LAST) w_next = S_IDLE;
      end
      S_COMMIT: begin
        // An exception overrides the destination so software sees the fault in rstatus.
        if (r_exc) begin
          w_wb_req  = 1'b1;
          w_wb_reg  = RSTATUS;
          w_wb_data = r_op ? DIV_CODE : MULT_CODE;
        end else if (r_rd != 5'd0) begin
          w_wb_req  = 1'b1;
          w_wb_reg  = r_rd;
          w_wb_data = r_res;
        end
        if (!w_wb_req || bus.wb_grant) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op          <= 1'b0;
      r_rd          <= 5'd0;
      r_a           <= 32'd0;
      r_b           <= 32'd0;
      r_res         <= 32'd0;
      r_exc         <= 1'b0;
      r_cnt         <= 6'd0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= bus.issue_op;
        r_rd <= bus.issue_rd;
        r_a  <= bus.issue_a;
        r_b  <= bus.issue_b;
      end
      // Saturate so a large TIMEOUT can never alias back to an early count.
      if (r_state == S_START)                        r_cnt <= 6'd0;
      else if (r_state == S_WAIT && r_cnt != CNT_MAX) r_cnt <= r_cnt + 6'd1;
      if (w_ready) begin
        r_res <= bus.md_result;
        r_exc <= bus.md_exception;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign w_rd_hit      = (r_rd != 5'd0) && ((bus.dec_rs1 == r_rd) || (bus.dec_rs2 == r_rd));
  assign w_rstatus_hit = (bus.dec_rs1 == RSTATUS) || (bus.dec_rs2 == RSTATUS);

  assign bus.busy         = (r_state != S_IDLE);
  assign bus.issue_stall  = bus.issue_valid && (r_state != S_IDLE);
  assign bus.hazard_stall = bus.busy && (w_rd_hit || w_rstatus_hit);
  assign bus.md_a         = r_a;
  assign bus.md_b         = r_b;
  assign bus.md_mult      = (r_state == S_START) && !r_op;
  assign bus.md_div       = (r_state == S_START) && r_op;
  assign bus.wb_req       = w_wb_req;
  assign bus.wb_reg       = w_wb_reg;
  assign bus.wb_data      = w_wb_data;
  assign bus.timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: a behavioural multdiv unit answers start pulses, and each
// operation's writeback is predicted from the issued instruction alone.
module tb_multdiv_sequencer;
  logic clock;
  logic reset;
  multdiv_seq_if bus();

  multdiv_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  int lat_cfg     = 1;
  bit exc_cfg     = 1'b0;
  bit no_ready    = 1'b0;
  int mult_pulses = 0;
  int div_pulses  = 0;
  logic [31:0] m_a, m_b;
  bit m_div;

  typedef struct {
    bit          op;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    bit          exc;
    int          gdelay;
  } vec_t;

  vec_t tab[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Behavioural multdiv: computes from the operands it sees at the start pulse.
  initial begin
    bus.md_ready     = 1'b0;
    bus.md_result    = 32'd0;
    bus.md_exception = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.md_mult || bus.md_div) begin
        if (bus.md_mult) mult_pulses++;
        if (bus.md_div)  div_pulses++;
        m_a   = bus.md_a;
        m_b   = bus.md_b;
        m_div = bus.md_div;
        if (!no_ready) begin
          repeat (lat_cfg) @(posedge clock);
          #1;
          bus.md_ready     = 1'b1;
          bus.md_result    = m_div ? ((m_b == 32'd0) ? 32'd0 : m_a / m_b) : m_a * m_b;
          bus.md_exception = exc_cfg;
          @(posedge clock);
          #1;
          bus.md_ready     = 1'b0;
          bus.md_exception = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.md_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic issue(input bit op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock);
    #1;
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_rd    = rd;
    bus.issue_a     = a;
    bus.issue_b     = b;
    @(posedge clock);
    #1;
    bus.issue_valid = 1'b0;
  endtask

  task automatic do_op(input string tag, input bit op, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input bit exc, input int gdelay);
    bit exp_req;
    logic [4:0] exp_reg;
    logic [31:0] exp_data;
    bit ok;
    int m0, d0;
    exp_req = exc || (rd != 5'd0);
    exp_reg = exc ? 5'd30 : rd;
    if (exc)           exp_data = op ? 32'd5 : 32'd4;
    else if (!exp_req) exp_data = 32'd0;
    else if (op)       exp_data = (b == 32'd0) ? 32'd0 : a / b;
    else               exp_data = a * b;
    if (!exp_req) exp_reg = 5'd0;
    lat_cfg = lat;
    exc_cfg = exc;
    no_ready = 1'b0;
    bus.wb_grant = (gdelay == 0);
    m0 = mult_pulses;
    d0 = div_pulses;
    issue(op, rd, a, b);
    @(negedge clock);
    chk({tag, "/busy_start"}, 32'(bus.busy), 32'd1);
    chk({tag, "/md_mult"}, 32'(bus.md_mult), 32'(!op));
    chk({tag, "/md_div"}, 32'(bus.md_div), 32'(op));
    wait_ready(ok);
    if (!ok) begin
      bound_fail({tag, "/md_ready"});
      return;
    end
    @(negedge clock);
    chk({tag, "/wb_req"}, 32'(bus.wb_req), 32'(exp_req));
    chk({tag, "/wb_reg"}, 32'(bus.wb_reg), 32'(exp_reg));
    chk({tag, "/wb_data"}, bus.wb_data, exp_data);
    bus.dec_rs1 = rd;
    bus.dec_rs2 = 5'd0;
    #1;
    chk({tag, "/hazard_rd"}, 32'(bus.hazard_stall), 32'(rd != 5'd0));
    bus.dec_rs1 = 5'd0;
    bus.dec_rs2 = 5'd30;
    #1;
    chk({tag, "/hazard_rstatus"}, 32'(bus.hazard_stall), 32'd1);
    if (exp_req && gdelay > 0) begin
      for (int g = 1; g < gdelay; g++) begin
        @(negedge clock);
        chk({tag, "/hold_req"}, 32'(bus.wb_req), 32'd1);
        chk({tag, "/hold_reg"}, 32'(bus.wb_reg), 32'(exp_reg));
        chk({tag, "/hold_data"}, bus.wb_data, exp_data);
      end
    end
    bus.wb_grant = 1'b1;
    @(negedge clock);
    bus.dec_rs1 = rd;
    #1;
    chk({tag, "/busy_after"}, 32'(bus.busy), 32'd0);
    chk({tag, "/wb_req_after"}, 32'(bus.wb_req), 32'd0);
    chk({tag, "/hazard_after"}, 32'(bus.hazard_stall), 32'd0);
    chk({tag, "/md_a_hold"}, bus.md_a, a);
    chk({tag, "/md_b_hold"}, bus.md_b, b);
    chk({tag, "/mult_count"}, 32'(mult_pulses), 32'(m0 + (op ? 0 : 1)));
    chk({tag, "/div_count"}, 32'(div_pulses), 32'(d0 + (op ? 1 : 0)));
    bus.dec_rs1 = 5'd0;
    bus.dec_rs2 = 5'd0;
  endtask

  initial begin
    bit ok;
    bit saw_req;
    int busy_cycles, m0, d0;
    bit r_op;
    logic [4:0] r_rd;
    logic [31:0] r_a, r_b;
    bit r_exc;

    bus.issue_valid = 1'b0;
    bus.issue_op    = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.issue_a     = 32'd0;
    bus.issue_b     = 32'd0;
    bus.dec_rs1     = 5'd0;
    bus.dec_rs2     = 5'd0;
    bus.wb_grant    = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst/busy", 32'(bus.busy), 32'd0);
    chk("rst/wb_req", 32'(bus.wb_req), 32'd0);
    chk("rst/wb_reg", 32'(bus.wb_reg), 32'd0);
    chk("rst/wb_data", bus.wb_data, 32'd0);
    chk("rst/md_a", bus.md_a, 32'd0);
    chk("rst/md_b", bus.md_b, 32'd0);
    chk("rst/md_pulse", 32'({bus.md_mult, bus.md_div}), 32'd0);
    chk("rst/timeout_err", 32'(bus.timeout_err), 32'd0);
    chk("rst/stalls", 32'({bus.issue_stall, bus.hazard_stall}), 32'd0);
    reset = 1'b1;

    tab[0] = '{1'b0, 5'd5,  32'd6,          32'd7,  17, 1'b0, 0};
    tab[1] = '{1'b1, 5'd9,  32'd100,        32'd7,  3,  1'b1, 0};
    tab[2] = '{1'b0, 5'd9,  32'd100,        32'd7,  4,  1'b1, 0};
    tab[3] = '{1'b1, 5'd12, 32'd100,        32'd7,  1,  1'b0, 0};
    tab[4] = '{1'b0, 5'd0,  32'd3,          32'd4,  2,  1'b0, 0};
    tab[5] = '{1'b0, 5'd7,  32'hFFFF_FFFF,  32'd2,  5,  1'b0, 4};
    tab[6] = '{1'b1, 5'd31, 32'h8000_0000,  32'd16, 2,  1'b0, 1};
    tab[7] = '{1'b1, 5'd3,  32'd55,         32'd0,  6,  1'b1, 2};
    for (int i = 0; i < 8; i++)
      do_op($sformatf("tab%0d", i), tab[i].op, tab[i].rd, tab[i].a, tab[i].b,
            tab[i].lat, tab[i].exc, tab[i].gdelay);

    for (int i = 0; i < 20; i++) begin
      r_op  = 1'($urandom_range(0, 1));
      r_rd  = 5'($urandom_range(0, 31));
      r_a   = $urandom;
      r_b   = $urandom;
      r_exc = ($urandom_range(0, 7) == 0);
      if (r_op && r_b == 32'd0) r_b = 32'd1;
      do_op($sformatf("rnd%0d", i), r_op, r_rd, r_a, r_b, int'($urandom_range(1, 10)), r_exc,
            int'($urandom_range(0, 2)));
    end

    // Back-to-back issue: the second op waits for the first grant.
    lat_cfg = 6;
    exc_cfg = 1'b0;
    bus.wb_grant = 1'b1;
    m0 = mult_pulses;
    d0 = div_pulses;
    @(posedge clock);
    #1;
    bus.issue_valid = 1'b1;
    bus.issue_op = 1'b0; bus.issue_rd = 5'd3; bus.issue_a = 32'd5;  bus.issue_b = 32'd5;
    @(posedge clock);
    #1;
    bus.issue_op = 1'b1; bus.issue_rd = 5'd4; bus.issue_a = 32'd50; bus.issue_b = 32'd5;
    @(negedge clock);
    chk("b2b/stall_start", 32'(bus.issue_stall), 32'd1);
    @(negedge clock);
    chk("b2b/stall_wait", 32'(bus.issue_stall), 32'd1);
    wait_ready(ok);
    if (!ok) bound_fail("b2b/ready1");
    @(negedge clock);
    chk("b2b/wb_reg1", 32'(bus.wb_reg), 32'd3);
    chk("b2b/wb_data1", bus.wb_data, 32'd25);
    chk("b2b/stall_commit", 32'(bus.issue_stall), 32'd1);
    chk("b2b/no_second_pulse", 32'(div_pulses), 32'(d0));
    @(negedge clock);
    chk("b2b/idle_busy", 32'(bus.busy), 32'd0);
    chk("b2b/idle_stall", 32'(bus.issue_stall), 32'd0);
    @(posedge clock);
    #1;
    bus.issue_valid = 1'b0;
    @(negedge clock);
    chk("b2b/md_div2", 32'(bus.md_div), 32'd1);
    wait_ready(ok);
    if (!ok) bound_fail("b2b/ready2");
    @(negedge clock);
    chk("b2b/wb_reg2", 32'(bus.wb_reg), 32'd4);
    chk("b2b/wb_data2", bus.wb_data, 32'd10);
    @(negedge clock);
    chk("b2b/busy_end", 32'(bus.busy), 32'd0);
    chk("b2b/pulses", 32'((mult_pulses - m0) * 16 + (div_pulses - d0)), 32'h11);

    // Timeout: the unit never answers.
    chk("to/err_before", 32'(bus.timeout_err), 32'd0);
    no_ready = 1'b1;
    saw_req = 1'b0;
    busy_cycles = 0;
    issue(1'b0, 5'd6, 32'd2, 32'd3);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.wb_req) saw_req = 1'b1;
      if (!bus.busy) break;
      busy_cycles++;
    end
    chk("to/busy_cycles", 32'(busy_cycles), 32'd41);
    chk("to/err", 32'(bus.timeout_err), 32'd1);
    chk("to/no_wb", 32'(saw_req), 32'd0);
    chk("to/idle", 32'(bus.busy), 32'd0);
    no_ready = 1'b0;

    // Reset mid-WAIT, then a late md_ready.
    lat_cfg = 20;
    issue(1'b1, 5'd8, 32'd90, 32'd9);
    repeat (6) @(negedge clock);
    chk("rw/in_wait", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    bus.dec_rs2 = 5'd30;
    #1;
    chk("rw/busy", 32'(bus.busy), 32'd0);
    chk("rw/hazard", 32'(bus.hazard_stall), 32'd0);
    chk("rw/timeout_err", 32'(bus.timeout_err), 32'd0);
    chk("rw/md_a", bus.md_a, 32'd0);
    chk("rw/md_b", bus.md_b, 32'd0);
    chk("rw/wb", 32'({bus.wb_req, bus.md_mult, bus.md_div}), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    saw_req = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (bus.wb_req) saw_req = 1'b1;
      if (bus.busy) busy_cycles++;
    end
    chk("rw/no_commit", 32'(saw_req), 32'd0);
    chk("rw/stay_idle", 32'(busy_cycles), 32'd0);
    bus.dec_rs2 = 5'd0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end
endmodule
